// File: rtl/chunked_adder_if.sv
// Request/result handshake bundle for chunked_adder.
// The master side presents operands and consumes the result; the adder is the slave.
interface chunked_adder_if #(
    parameter int WIDTH = 16
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_carry_in;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_s;
    logic             o_carry_out;
    logic             o_overflow;

    modport master (
        output i_valid, i_a, i_b, i_carry_in, i_sub, i_ready,
        input  o_ready, o_valid, o_s, o_carry_out, o_overflow
    );

    modport slave (
        input  i_valid, i_a, i_b, i_carry_in, i_sub, i_ready,
        output o_ready, o_valid, o_s, o_carry_out, o_overflow
    );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, rippling the
// carry through a register, and presents the result on a valid/ready port.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    chunked_adder_if.slave  bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;

    logic [CHUNK-1:0] a_ch, b_ch, ch_s;
    logic             ch_c;
    logic             last;

    // b_q holds the already-inverted operand in subtract mode
    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(cnt_q) == i) begin
                a_ch = a_q[i*CHUNK +: CHUNK];
                b_ch = b_q[i*CHUNK +: CHUNK];
            end
        end
        {ch_c, ch_s} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, c_q};
        last = (int'(cnt_q) == NCH - 1);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        co_d    = co_q;
        ov_d    = ov_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    a_d     = bus.i_a;
                    b_d     = bus.i_sub ? ~bus.i_b : bus.i_b;
                    c_d     = bus.i_sub | bus.i_carry_in;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int i = 0; i < NCH; i++) begin
                    if (int'(cnt_q) == i) acc_d[i*CHUNK +: CHUNK] = ch_s;
                end
                c_d   = ch_c;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    s_d  = acc_d;
                    co_d = ch_c;
                    // a^b^s at the MSB recovers the carry into it
                    ov_d = a_ch[CHUNK-1] ^ b_ch[CHUNK-1]
                         ^ ch_s[CHUNK-1] ^ ch_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.o_ready     = (state_q == IDLE);
    assign bus.o_valid     = (state_q == DONE);
    assign bus.o_s         = s_q;
    assign bus.o_carry_out = co_q;
    assign bus.o_overflow  = ov_q;
endmodule

// File: tb/tb_chunked_adder.sv
// Directed vectors plus a random sweep across three chunk sizes that
// share one stimulus stream (CHUNK=4, 16 and 1 at WIDTH=16).
module tb_chunked_adder;
    logic        clk;
    logic        rst;
    logic        valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        ready;

    int checks;
    int errors;
    int lat4, lat16, lat1;

    chunked_adder_if #(.WIDTH(16)) b4 ();
    chunked_adder_if #(.WIDTH(16)) b16 ();
    chunked_adder_if #(.WIDTH(16)) b1 ();

    assign b4.i_valid     = valid;
    assign b4.i_a         = a;
    assign b4.i_b         = b;
    assign b4.i_carry_in  = cin;
    assign b4.i_sub       = sub;
    assign b4.i_ready     = ready;
    assign b16.i_valid    = valid;
    assign b16.i_a        = a;
    assign b16.i_b        = b;
    assign b16.i_carry_in = cin;
    assign b16.i_sub      = sub;
    assign b16.i_ready    = ready;
    assign b1.i_valid     = valid;
    assign b1.i_a         = a;
    assign b1.i_b         = b;
    assign b1.i_carry_in  = cin;
    assign b1.i_sub       = sub;
    assign b1.i_ready     = ready;

    chunked_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
        .i_clk(clk), .i_reset(rst), .bus(b4)
    );
    chunked_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .i_clk(clk), .i_reset(rst), .bus(b16)
    );
    chunked_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
        .i_clk(clk), .i_reset(rst), .bus(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Accept one request on all three DUTs and wait (bounded) for each result.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                          input logic icin, input logic isub);
        @(negedge clk);
        chk("ready_idle", {31'd0, b4.o_ready}, 32'd1);
        valid = 1'b1;
        a     = ia;
        b     = ib;
        cin   = icin;
        sub   = isub;
        @(posedge clk);
        #1;
        valid = 1'b0;
        a     = ~ia;
        b     = ia ^ ib;
        cin   = ~icin;
        sub   = ~isub;
        lat4  = 0;
        lat16 = 0;
        lat1  = 0;
        for (int e = 1; e <= 40; e++) begin
            if (lat4 != 0 && lat16 != 0 && lat1 != 0) break;
            @(posedge clk);
            #1;
            if (lat4 == 0 && b4.o_valid) lat4 = e;
            if (lat16 == 0 && b16.o_valid) lat16 = e;
            if (lat1 == 0 && b1.o_valid) lat1 = e;
        end
    endtask

    task automatic release_op();
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
    endtask

    initial begin
        logic [15:0] ra, rb, beff, ms;
        logic        rc, rs, ce, mco, mov;
        checks = 0;
        errors = 0;
        valid  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        sub    = 1'b0;
        ready  = 1'b0;

        vt[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vt[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        rst = 1'b1;
        #1;
        chk("rst_ready", {31'd0, b4.o_ready}, 32'd1);
        chk("rst_valid", {31'd0, b4.o_valid}, 32'd0);
        chk("rst_s", {16'd0, b4.o_s}, 32'd0);
        chk("rst_co", {31'd0, b4.o_carry_out}, 32'd0);
        chk("rst_ov", {31'd0, b4.o_overflow}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub);
            chk($sformatf("v%0d_lat4", i), lat4, 32'd4);
            chk($sformatf("v%0d_s", i), {16'd0, b4.o_s}, {16'd0, vt[i].s});
            chk($sformatf("v%0d_co", i), {31'd0, b4.o_carry_out},
                {31'd0, vt[i].co});
            chk($sformatf("v%0d_ov", i), {31'd0, b4.o_overflow},
                {31'd0, vt[i].ov});
            chk($sformatf("v%0d_lat16", i), lat16, 32'd1);
            chk($sformatf("v%0d_s16", i), {16'd0, b16.o_s}, {16'd0, vt[i].s});
            chk($sformatf("v%0d_lat1", i), lat1, 32'd16);
            chk($sformatf("v%0d_s1", i), {16'd0, b1.o_s}, {16'd0, vt[i].s});
            release_op();
            chk($sformatf("v%0d_idle_hold", i), {16'd0, b4.o_s},
                {16'd0, vt[i].s});
            chk($sformatf("v%0d_idle_rdy", i), {31'd0, b4.o_ready}, 32'd1);
        end

        // Backpressure: new request held off while the result waits
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            valid = 1'b1;
            a     = 16'hAAAA;
            b     = 16'h5555;
            @(posedge clk);
            #1;
            chk("bp_valid", {31'd0, b4.o_valid}, 32'd1);
            chk("bp_ready", {31'd0, b4.o_ready}, 32'd0);
            chk("bp_s", {16'd0, b4.o_s}, 32'h0100);
            chk("bp_co", {31'd0, b4.o_carry_out}, 32'd0);
        end
        @(negedge clk);
        valid = 1'b0;
        release_op();
        chk("bp_rel_ready", {31'd0, b4.o_ready}, 32'd1);
        chk("bp_rel_valid", {31'd0, b4.o_valid}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("bp_no_accept", {31'd0, b4.o_ready}, 32'd1);
        chk("bp_hold_s", {16'd0, b4.o_s}, 32'h0100);

        // Reset in flight after two BUSY edges
        @(negedge clk);
        valid = 1'b1;
        a     = 16'hFFFF;
        b     = 16'h0001;
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("busy_ready", {31'd0, b4.o_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, b4.o_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, b4.o_ready}, 32'd1);
        chk("mid_rst_s", {16'd0, b4.o_s}, 32'd0);
        chk("mid_rst_co", {31'd0, b4.o_carry_out}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        chk("post_rst_lat", lat4, 32'd4);
        chk("post_rst_s", {16'd0, b4.o_s}, 32'h5555);
        release_op();

        // Random sweep against a full-width reference
        for (int n = 0; n < 1000; n++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom);
            rs   = 1'($urandom);
            beff = rs ? ~rb : rb;
            ce   = rs ? 1'b1 : rc;
            {mco, ms} = {1'b0, ra} + {1'b0, beff} + {16'd0, ce};
            mov  = (ra[15] == beff[15]) && (ms[15] != ra[15]);
            run_op(ra, rb, rc, rs);
            chk("rnd_lat16", lat16, 32'd1);
            chk("rnd_lat1", lat1, 32'd16);
            chk("rnd_lat4", lat4, 32'd4);
            chk("rnd_r16", {15'd0, b16.o_s, b16.o_carry_out, b16.o_overflow},
                {15'd0, ms, mco, mov});
            chk("rnd_r1", {15'd0, b1.o_s, b1.o_carry_out, b1.o_overflow},
                {15'd0, ms, mco, mov});
            chk("rnd_r4", {15'd0, b4.o_s, b4.o_carry_out, b4.o_overflow},
                {15'd0, ms, mco, mov});
            release_op();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
